reg_to_obi_mem: RTL and testbench

- Downstream stage of the AXI-Lite-to-regbus converter. Accepts one register-interface request at a time and drives an OBI-style memory port (req/gnt address phase, rvalid response phase).
- Returns rdata/error to the regbus in the cycle the transaction completes.
- Adds an alignment check and a response timeout with drain, so a stuck memory cannot hang the bus.

---
 rtl/reg_to_obi_mem.sv | 158 +++++++++++++++
 tb/tb_reg_to_obi_mem.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_to_obi_mem.sv
// Regbus-to-OBI memory bridge: one transaction at a time, with an alignment check
// and a response timeout that drains the late response before accepting new work.
package reg_to_obi_mem_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;
endpackage

module reg_to_obi_mem #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter type         reg_req_t      = reg_to_obi_mem_pkg::reg_req_t,
  parameter type         reg_rsp_t      = reg_to_obi_mem_pkg::reg_rsp_t
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  reg_req_t                reg_req_i,
  output reg_rsp_t                reg_rsp_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_err_i
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BE_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  error_q, error_d;
  logic                  drain_q, drain_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      drain_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    error_d = error_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (reg_req_i.valid) begin
          addr_d  = reg_req_i.addr;
          we_d    = reg_req_i.write;
          wdata_d = reg_req_i.wdata;
          be_d    = reg_req_i.wstrb;
          rdata_d = '0;
          if (|(reg_req_i.addr & OFF_MASK)) begin
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            error_d = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem_rvalid_i) begin
          error_d = mem_err_i;
          rdata_d = we_q ? '0 : mem_rdata_i;
          state_d = DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          // The late response is still owed by the memory; DRAIN swallows it.
          error_d = 1'b1;
          rdata_d = '0;
          drain_d = 1'b1;
          state_d = DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = drain_q ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (mem_rvalid_i) begin
          drain_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = (state_q == REQ);
    mem_addr_o  = addr_q & ~OFF_MASK;
    mem_we_o    = we_q;
    mem_wdata_o = wdata_q;
    mem_be_o    = be_q;
    reg_rsp_o   = '0;
    if (state_q == DONE) begin
      reg_rsp_o.ready = 1'b1;
      reg_rsp_o.rdata = rdata_q;
      reg_rsp_o.error = error_q;
    end
  end

endmodule

// File: tb/tb_reg_to_obi_mem.sv
// Directed bench for reg_to_obi_mem with a short response timeout (4 cycles).
module tb_reg_to_obi_mem;
  import reg_to_obi_mem_pkg::*;

  logic        clk;
  logic        rst_n;
  reg_req_t    req;
  reg_rsp_t    rsp;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int n_cmp = 0;
  int n_err = 0;

  reg_to_obi_mem #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .reg_req_i   (req),
    .reg_rsp_o   (rsp),
    .mem_req_o   (mem_req),
    .mem_gnt_i   (mem_gnt),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i (mem_rdata),
    .mem_err_i   (mem_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are examined 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic v, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s);
    req.valid = v;
    req.addr  = a;
    req.write = w;
    req.wdata = d;
    req.wstrb = s;
  endtask

  task automatic drive_mem(input logic g, input logic rv, input logic [31:0] rd, input logic e);
    mem_gnt    = g;
    mem_rvalid = rv;
    mem_rdata  = rd;
    mem_err    = e;
  endtask

  task automatic check_idle_rsp(input string tag);
    check({tag, "_ready"}, 64'(rsp.ready), 64'd0);
    check({tag, "_rdata"}, 64'(rsp.rdata), 64'd0);
    check({tag, "_error"}, 64'(rsp.error), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_req(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive_mem(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    step();
    // Reset state
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_be", 64'(mem_be), 64'd0);
    check_idle_rsp("rst");
    rst_n = 1'b1;
    step();

    // Aligned read, immediate grant, response one cycle later
    drive_req(1'b1, 32'h10, 1'b0, 32'h0, 4'hF);
    step();
    check("rd_req", 64'(mem_req), 64'd1);
    check("rd_addr", 64'(mem_addr), 64'h10);
    check("rd_we", 64'(mem_we), 64'd0);
    check_idle_rsp("rd_c1");
    mem_gnt = 1'b1;
    step();
    check("rd_req_c2", 64'(mem_req), 64'd0);
    check("rd_ready_c2", 64'(rsp.ready), 64'd0);
    drive_mem(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    step();
    check("rd_ready", 64'(rsp.ready), 64'd1);
    check("rd_rdata", 64'(rsp.rdata), 64'hDEADBEEF);
    check("rd_error", 64'(rsp.error), 64'd0);
    drive_req(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive_mem(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check_idle_rsp("rd_c4");
    check("rd_req_c4", 64'(mem_req), 64'd0);

    // Write with grant held off for three REQ cycles
    drive_req(1'b1, 32'h24, 1'b1, 32'h12345678, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("wr_req_%0d", i), 64'(mem_req), 64'd1);
      check($sformatf("wr_addr_%0d", i), 64'(mem_addr), 64'h24);
      check($sformatf("wr_we_%0d", i), 64'(mem_we), 64'd1);
      check($sformatf("wr_wdata_%0d", i), 64'(mem_wdata), 64'h12345678);
      check($sformatf("wr_be_%0d", i), 64'(mem_be), 64'b0101);
      check($sformatf("wr_ready_%0d", i), 64'(rsp.ready), 64'd0);
    end
    // A response in the grant cycle must not complete the transaction
    drive_mem(1'b1, 1'b1, 32'hAAAA5555, 1'b1);
    step();
    check("wr_req_resp", 64'(mem_req), 64'd0);
    drive_mem(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check("wr_ready_early", 64'(rsp.ready), 64'd0);
    drive_mem(1'b0, 1'b1, 32'hAAAA5555, 1'b0);
    step();
    check("wr_ready", 64'(rsp.ready), 64'd1);
    check("wr_rdata", 64'(rsp.rdata), 64'd0);
    check("wr_error", 64'(rsp.error), 64'd0);
    drive_req(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive_mem(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check_idle_rsp("wr_after");

    // Misaligned read: no memory access, error response the next cycle
    drive_req(1'b1, 32'h13, 1'b0, 32'h0, 4'hF);
    step();
    check("mis_req", 64'(mem_req), 64'd0);
    check("mis_ready", 64'(rsp.ready), 64'd1);
    check("mis_error", 64'(rsp.error), 64'd1);
    check("mis_rdata", 64'(rsp.rdata), 64'd0);
    drive_req(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    step();
    check("mis_req_after", 64'(mem_req), 64'd0);
    check_idle_rsp("mis_after");

    // Memory error on a read
    drive_req(1'b1, 32'h40, 1'b0, 32'h0, 4'hF);
    step();
    check("merr_req", 64'(mem_req), 64'd1);
    check("merr_addr", 64'(mem_addr), 64'h40);
    mem_gnt = 1'b1;
    step();
    drive_mem(1'b0, 1'b1, 32'hFFFF0000, 1'b1);
    step();
    check("merr_ready", 64'(rsp.ready), 64'd1);
    check("merr_error", 64'(rsp.error), 64'd1);
    check("merr_rdata", 64'(rsp.rdata), 64'hFFFF0000);
    drive_req(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive_mem(1'b0, 1'b0, 32'h0, 1'b0);
    step();

    // Timeout: no response after grant
    drive_req(1'b1, 32'h50, 1'b0, 32'h0, 4'hF);
    step();
    check("to_req", 64'(mem_req), 64'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_wait_ready_%0d", i), 64'(rsp.ready), 64'd0);
      check($sformatf("to_wait_req_%0d", i), 64'(mem_req), 64'd0);
      step();
    end
    check("to_ready", 64'(rsp.ready), 64'd1);
    check("to_error", 64'(rsp.error), 64'd1);
    check("to_rdata", 64'(rsp.rdata), 64'd0);
    drive_req(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    step();
    // Draining: a new request must stall until the late response arrives
    drive_req(1'b1, 32'h60, 1'b0, 32'h0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("drain_req_%0d", i), 64'(mem_req), 64'd0);
      check($sformatf("drain_ready_%0d", i), 64'(rsp.ready), 64'd0);
      if (i == 9) drive_mem(1'b0, 1'b1, 32'hCAFECAFE, 1'b1);
      step();
    end
    drive_mem(1'b0, 1'b0, 32'h0, 1'b0);
    check("drain_idle_req", 64'(mem_req), 64'd0);
    check_idle_rsp("drain_idle");
    step();
    check("post_req", 64'(mem_req), 64'd1);
    check("post_addr", 64'(mem_addr), 64'h60);
    mem_gnt = 1'b1;
    step();
    drive_mem(1'b0, 1'b1, 32'h0BADF00D, 1'b0);
    step();
    check("post_ready", 64'(rsp.ready), 64'd1);
    check("post_rdata", 64'(rsp.rdata), 64'h0BADF00D);
    check("post_error", 64'(rsp.error), 64'd0);
    drive_req(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive_mem(1'b0, 1'b0, 32'h0, 1'b0);
    step();

    // Reset while waiting in RESP
    drive_req(1'b1, 32'h70, 1'b1, 32'h11223344, 4'hF);
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    drive_req(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    step();
    check("mrst_req", 64'(mem_req), 64'd0);
    check("mrst_addr", 64'(mem_addr), 64'd0);
    check("mrst_we", 64'(mem_we), 64'd0);
    check("mrst_be", 64'(mem_be), 64'd0);
    check_idle_rsp("mrst");
    rst_n = 1'b1;
    drive_req(1'b1, 32'h74, 1'b0, 32'h0, 4'hF);
    step();
    check("fresh_req", 64'(mem_req), 64'd1);
    check("fresh_addr", 64'(mem_addr), 64'h74);
    mem_gnt = 1'b1;
    step();
    drive_mem(1'b0, 1'b1, 32'h55AA55AA, 1'b0);
    step();
    check("fresh_ready", 64'(rsp.ready), 64'd1);
    check("fresh_rdata", 64'(rsp.rdata), 64'h55AA55AA);
    check("fresh_error", 64'(rsp.error), 64'd0);
    drive_req(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive_mem(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check_idle_rsp("fresh_after");

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
